uart_rx_deser: RTL and testbench

Serial receive front end of the UART: samples the asynchronous `rxd` line at 16x the bit rate and assembles start/data/parity/stop frames. Each good byte is pushed into the downstream 16-deep RX FIFO via a single-cycle write strobe. Framing, parity and overrun conditions are flagged as sticky error bits for the APB status register.

---
 rtl/uart_rx_deser.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: 16x oversampled start/data/parity/stop framing,
// single-cycle FIFO write strobe and sticky framing/parity/overrun flags.
module uart_rx_deser #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rxd,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             fifo_full,
  input  logic             err_clr,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_wr_data,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rxd_meta_q, rxs_q, rxs_prev_q;
  logic             fall;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_last;
  logic             tick;
  logic             bit_end;
  logic [3:0]       scnt_q, scnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_q, perr_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             frame_err_q, parity_err_q, overrun_err_q;
  logic             set_frame, set_parity, set_overrun;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall     = rxs_prev_q & ~rxs_q;
  assign div_last = (baud_div <= DIV_W'(1)) ? '0 : (baud_div - DIV_W'(1));
  assign tick     = (state_q != S_IDLE) && (div_cnt_q == div_last);
  assign bit_end  = tick && (scnt_q == 4'd15);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    set_frame   = 1'b0;
    set_parity  = 1'b0;
    set_overrun = 1'b0;

    if (state_q != S_IDLE) begin
      if (tick) begin
        div_cnt_d = '0;
        scnt_d    = scnt_q + 4'd1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        scnt_d    = '0;
        if (rx_en && fall) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Mid start bit: a line back high means the edge was a glitch.
        if (tick && (scnt_q == 4'd7)) begin
          if (!rxs_q) begin
            state_d = S_DATA;
            scnt_d  = '0;
            bcnt_d  = '0;
            perr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {rxs_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = parity_en ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          perr_d  = ((^shift_q) ^ rxs_q) != parity_odd;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          if (!rxs_q) begin
            set_frame = 1'b1;
          end else if (fifo_full) begin
            set_overrun = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_data_d  = shift_q;
            set_parity = perr_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disabling the receiver abandons any frame without side effects.
    if (!rx_en) begin
      state_d     = S_IDLE;
      wr_en_d     = 1'b0;
      wr_data_d   = wr_data_q;
      set_frame   = 1'b0;
      set_parity  = 1'b0;
      set_overrun = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= '0;
      scnt_q        <= '0;
      bcnt_q        <= '0;
      shift_q       <= '0;
      perr_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      scnt_q        <= scnt_d;
      bcnt_q        <= bcnt_d;
      shift_q       <= shift_d;
      perr_q        <= perr_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      // Set has priority over a coincident clear.
      frame_err_q   <= set_frame   | (frame_err_q   & ~err_clr);
      parity_err_q  <= set_parity  | (parity_err_q  & ~err_clr);
      overrun_err_q <= set_overrun | (overrun_err_q & ~err_clr);
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign frame_err    = frame_err_q;
  assign parity_err   = parity_err_q;
  assign overrun_err  = overrun_err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed scenarios plus randomized
// frames checked against an outcome model built from frame-level rules.
module tb_uart_rx_deser;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             rxd = 1'b1;
  logic             rx_en = 1'b0;
  logic [DIV_W-1:0] baud_div = 16'd4;
  logic             parity_en = 1'b0;
  logic             parity_odd = 1'b0;
  logic             fifo_full = 1'b0;
  logic             err_clr = 1'b0;
  logic             fifo_wr_en;
  logic [7:0]       fifo_wr_data;
  logic             frame_err, parity_err, overrun_err, busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned wr_cyc = 0;
  logic [7:0]  wr_q[$];

  uart_rx_deser #(.DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rxd          (rxd),
    .rx_en        (rx_en),
    .baud_div     (baud_div),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .fifo_full    (fifo_full),
    .err_clr      (err_clr),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun_err  (overrun_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every clock the strobe is high counts as one write.
  always @(negedge clk) begin
    if (rstn && fifo_wr_en) begin
      wr_q.push_back(fifo_wr_data);
      wr_cyc = cyc;
      $display("write data=0x%02h at cycle %0d", fifo_wr_data, cyc);
    end
  end

  task automatic drive_bit(input logic v);
    int n;
    n = (baud_div <= 1) ? 16 : 16 * int'(baud_div);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic has_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fifo_wr_en, fifo_wr_data, frame_err, parity_err, overrun_err, busy} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got wr=%b data=%02h fe=%b pe=%b oe=%b busy=%b, want all 0",
               fifo_wr_en, fifo_wr_data, frame_err, parity_err, overrun_err, busy);
    end
    rstn = 1'b1;
    rx_en = 1'b1;
    repeat (4) @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_8n1();
    int unsigned t0;
    int lat;
    baud_div = 16'd4;
    parity_en = 1'b0;
    wr_q.delete();
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 1) begin
      n_bad++;
      $display("FAIL 8n1_count: got %0d writes, want 1", wr_q.size());
    end
    if (wr_q.size() > 0) begin
      n_cmp++;
      if (wr_q[0] !== 8'hA5) begin
        n_bad++;
        $display("FAIL 8n1_data: got 0x%02h, want 0xA5", wr_q[0]);
      end
    end
    lat = int'(wr_cyc) - int'(t0);
    n_cmp++;
    if (lat < 152 * 4 - 4 || lat > 152 * 4 + 4) begin
      n_bad++;
      $display("FAIL 8n1_latency: got %0d clocks, want %0d +/-4", lat, 152 * 4);
    end
    n_cmp++;
    if ({frame_err, parity_err, overrun_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL 8n1_flags: got %b, want 000", {frame_err, parity_err, overrun_err});
    end
    $display("8n1: sent 0xA5, latency %0d clocks", lat);
  endtask

  task automatic test_glitch();
    wr_q.delete();
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_start: got busy=%b, want 1", busy);
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_end: got busy=%b, want 0", busy);
    end
    repeat (200) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_nowrite: got %0d writes fe=%b, want 0 writes fe=0", wr_q.size(), frame_err);
    end
    $display("glitch: 20-clock low pulse rejected");
  endtask

  task automatic test_parity();
    baud_div = 16'd4;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    wr_q.delete();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== 8'h3C) begin
      n_bad++;
      $display("FAIL parity_bad_write: got %0d writes first=0x%02h, want 1 write 0x3C",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00);
    end
    n_cmp++;
    if (parity_err !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_err_set: got %b, want 1", parity_err);
    end
    clear_errs();
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_err_clr: got %b, want 0", parity_err);
    end
    wr_q.delete();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 1 || parity_err !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_good: got %0d writes pe=%b, want 1 write pe=0", wr_q.size(), parity_err);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
    $display("parity: bad then good odd parity on 0x3C");
  endtask

  task automatic test_break();
    baud_div = 16'd4;
    wr_q.delete();
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 0 || frame_err !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_err: got %0d writes fe=%b, want 0 writes fe=1", wr_q.size(), frame_err);
    end
    clear_errs();
    rxd = 1'b0;
    repeat (40 * 64) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL break_idle: got busy=%b writes=%0d, want busy=0 writes=0", busy, wr_q.size());
    end
    // The single frame started by the break edge ends with a zero stop bit.
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_bad++;
      $display("FAIL break_frame_err: got %b, want 1", frame_err);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    clear_errs();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== 8'h5A || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL break_recover: got %0d writes first=0x%02h fe=%b, want 1 write 0x5A fe=0",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00, frame_err);
    end
    $display("break: frame error, held-low line, recovery with 0x5A");
  endtask

  task automatic test_overrun();
    wr_q.delete();
    fifo_full = 1'b1;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    fifo_full = 1'b0;
    n_cmp++;
    if (wr_q.size() != 0 || overrun_err !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: got %0d writes oe=%b, want 0 writes oe=1", wr_q.size(), overrun_err);
    end
    clear_errs();
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] !== 8'h22 || overrun_err !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_recover: got %0d writes first=0x%02h oe=%b, want 1 write 0x22 oe=0",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00, overrun_err);
    end
    $display("overrun: 0x11 dropped, 0x22 written");
  endtask

  task automatic test_rx_en();
    wr_q.delete();
    rxd = 1'b0;
    repeat (2 * 64) @(negedge clk);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rx_en_abort: got busy=%b, want 0", busy);
    end
    rxd = 1'b1;
    repeat (12 * 64) @(negedge clk);
    rx_en = 1'b1;
    n_cmp++;
    if (wr_q.size() != 0 || {frame_err, parity_err, overrun_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL rx_en_nowrite: got %0d writes flags=%b, want 0 writes flags=000",
               wr_q.size(), {frame_err, parity_err, overrun_err});
    end
    $display("rx_en: frame abandoned when disabled");
  endtask

  task automatic test_back_to_back();
    logic [7:0] third;
    wr_q.delete();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    n_cmp++;
    if (wr_q.size() != 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d writes, want 2", wr_q.size());
    end
    if (wr_q.size() == 2) begin
      n_cmp++;
      if (wr_q[0] !== 8'h00 || wr_q[1] !== 8'hFF) begin
        n_bad++;
        $display("FAIL b2b_data: got 0x%02h,0x%02h, want 0x00,0xFF", wr_q[0], wr_q[1]);
      end
    end
    // Third frame cut by reset in the middle of data bit 3.
    wr_q.delete();
    third = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(third[i]);
    rxd = third[3];
    repeat (32) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_wr_en, fifo_wr_data, frame_err, parity_err, overrun_err, busy} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_midframe: got wr=%b data=%02h fe=%b pe=%b oe=%b busy=%b, want all 0",
               fifo_wr_en, fifo_wr_data, frame_err, parity_err, overrun_err, busy);
    end
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * 64) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_nowrite: got %0d writes busy=%b, want 0 writes busy=0", wr_q.size(), busy);
    end
    $display("back_to_back: 0x00,0xFF received; third frame aborted by reset");
  endtask

  task automatic test_random();
    logic [7:0] data;
    logic       has_par, odd, good, stop, full, par_bit, want_par;
    int         exp_writes;
    logic [2:0] exp_flags;
    int unsigned divs[6] = '{0, 1, 2, 3, 4, 5};
    for (int f = 0; f < 16; f++) begin
      data     = 8'($urandom);
      has_par  = 1'($urandom);
      odd      = 1'($urandom);
      good     = ($urandom_range(0, 3) != 0);
      stop     = ($urandom_range(0, 4) != 0);
      full     = ($urandom_range(0, 3) == 0);
      baud_div = 16'(divs[$urandom_range(0, 5)]);
      parity_en  = has_par;
      parity_odd = odd;
      // Total count of ones over data plus parity is odd for odd parity.
      want_par = odd ? ($countones(data) % 2 == 0) : ($countones(data) % 2 == 1);
      par_bit  = good ? want_par : ~want_par;
      exp_writes = (stop && !full) ? 1 : 0;
      exp_flags  = {~stop, stop && !full && has_par && !good, stop && full};
      clear_errs();
      wr_q.delete();
      fifo_full = full;
      send_frame(data, has_par, par_bit, stop);
      drive_bit(1'b1);
      fifo_full = 1'b0;
      n_cmp++;
      if (wr_q.size() != exp_writes) begin
        n_bad++;
        $display("FAIL rand%0d_count: got %0d writes, want %0d", f, wr_q.size(), exp_writes);
      end
      if (exp_writes == 1 && wr_q.size() > 0) begin
        n_cmp++;
        if (wr_q[0] !== data) begin
          n_bad++;
          $display("FAIL rand%0d_data: got 0x%02h, want 0x%02h", f, wr_q[0], data);
        end
      end
      n_cmp++;
      if ({frame_err, parity_err, overrun_err} !== exp_flags) begin
        n_bad++;
        $display("FAIL rand%0d_flags: got fe/pe/oe=%b, want %b", f,
                 {frame_err, parity_err, overrun_err}, exp_flags);
      end
      $display("random frame %0d: data=0x%02h div=%0d par=%b odd=%b good=%b stop=%b full=%b",
               f, data, baud_div, has_par, odd, good, stop, full);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_rx_en();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
